seg7_scan_driver: RTL and testbench

Time-multiplexed scan driver for the board's 4-digit common-anode 7-segment display. It sits directly downstream of the 7-segment bus peripheral, which presents a 16-bit value register. The block latches that value once per frame, decodes each nibble to hex glyphs and cycles the anode selects. It also provides per-digit decimal points and 8-level brightness control.

---
 rtl/seg7_if.sv | 20 ++
 rtl/seg7_scan_driver.sv | 114 +++++++++++
 tb/tb_seg7_scan_driver.sv | 182 ++++++++++++++++++
 3 files changed

// File: rtl/seg7_if.sv
// Bus between the 7-segment peripheral and the scan driver.
// The peripheral drives the value, decimal points and brightness; the driver returns the display pins.
interface seg7_if;
    logic [15:0] VALUE_IN;
    logic [3:0]  DP_IN;
    logic [2:0]  BRIGHT;
    logic [7:0]  HEX_OUT;
    logic [3:0]  SEG_SELECT;
    logic        FRAME_TICK;

    modport master (
        output VALUE_IN, DP_IN, BRIGHT,
        input  HEX_OUT, SEG_SELECT, FRAME_TICK
    );

    modport slave (
        input  VALUE_IN, DP_IN, BRIGHT,
        output HEX_OUT, SEG_SELECT, FRAME_TICK
    );
endinterface

// File: rtl/seg7_scan_driver.sv
// Time-multiplexed driver for a 4-digit common-anode 7-segment display, frame-snapshotted input.
// Optional leading-zero blanking is enabled by defining SEG7_LZB_EN.
module seg7_scan_driver #(
    parameter int SCAN_BITS = 15
) (
    input  logic   CLK,
    input  logic   RESET,
    seg7_if.slave  bus
);
    if (SCAN_BITS < 3) begin : g_bad_scan_bits
        $error("seg7_scan_driver: SCAN_BITS must be at least 3");
    end

    localparam logic [SCAN_BITS-1:0] PRE_MAX = '1;

    logic [SCAN_BITS-1:0] pre;
    logic [1:0]           dig;
    logic [15:0]          shadow_value;
    logic [3:0]           shadow_dp;
    logic [2:0]           shadow_bright;

    logic       wrap;
    logic       frame_end;
    logic [2:0] phase;
    logic [3:0] nibble;
    logic [6:0] glyph;
    logic [6:0] seg_bits;
    logic [3:0] anode;

    assign wrap      = (pre == PRE_MAX);
    assign frame_end = wrap && (dig == 2'd3);
    assign phase     = pre[SCAN_BITS-1 -: 3];

    always_comb begin
        nibble = shadow_value[3:0];
        case (dig)
            2'd0: nibble = shadow_value[3:0];
            2'd1: nibble = shadow_value[7:4];
            2'd2: nibble = shadow_value[11:8];
            2'd3: nibble = shadow_value[15:12];
            default: nibble = shadow_value[3:0];
        endcase
    end

    // Glyphs are g..a, active-low; b and d are lowercase so they differ from 8 and 0.
    always_comb begin
        glyph = 7'h7F;
        case (nibble)
            4'h0: glyph = 7'b1000000;
            4'h1: glyph = 7'b1111001;
            4'h2: glyph = 7'b0100100;
            4'h3: glyph = 7'b0110000;
            4'h4: glyph = 7'b0011001;
            4'h5: glyph = 7'b0010010;
            4'h6: glyph = 7'b0000010;
            4'h7: glyph = 7'b1111000;
            4'h8: glyph = 7'b0000000;
            4'h9: glyph = 7'b0010000;
            4'hA: glyph = 7'b0001000;
            4'hB: glyph = 7'b0000011;
            4'hC: glyph = 7'b1000110;
            4'hD: glyph = 7'b0100001;
            4'hE: glyph = 7'b0000110;
            4'hF: glyph = 7'b0001110;
            default: glyph = 7'h7F;
        endcase
    end

`ifdef SEG7_LZB_EN
    logic blank;

    // A digit is blank when it and everything to its left is zero; digit 0 always shows.
    always_comb begin
        blank = 1'b0;
        case (dig)
            2'd3: blank = (shadow_value[15:12] == 4'h0);
            2'd2: blank = (shadow_value[15:8] == 8'h00);
            2'd1: blank = (shadow_value[15:4] == 12'h000);
            default: blank = 1'b0;
        endcase
    end

    assign seg_bits = blank ? 7'h7F : glyph;
`else
    assign seg_bits = glyph;
`endif

    assign anode = ~(4'b0001 << dig);
    assign bus.FRAME_TICK = frame_end;

    always_ff @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            pre            <= '0;
            dig            <= 2'd0;
            shadow_value   <= 16'h0000;
            shadow_dp      <= 4'h0;
            shadow_bright  <= 3'd0;
            bus.HEX_OUT    <= 8'hFF;
            bus.SEG_SELECT <= 4'hF;
        end else begin
            pre <= pre + 1'b1;
            if (wrap) begin
                dig <= dig + 2'd1;
            end
            if (frame_end) begin
                shadow_value  <= bus.VALUE_IN;
                shadow_dp     <= bus.DP_IN;
                shadow_bright <= bus.BRIGHT;
            end
            bus.HEX_OUT    <= {~shadow_dp[dig], seg_bits};
            bus.SEG_SELECT <= (phase <= shadow_bright) ? anode : 4'hF;
        end
    end
endmodule

// File: tb/tb_seg7_scan_driver.sv
// Bench for seg7_scan_driver: a cycle-count model of the display checked every cycle,
// plus fixed expectations from known frames and random input traffic.
module tb_seg7_scan_driver;
    localparam int SB    = 4;
    localparam int SLOT  = 1 << SB;
    localparam int FRAME = 4 * SLOT;
    localparam int PH    = SLOT / 8;

    logic CLK = 1'b0;
    logic RESET = 1'b1;

    seg7_if bus ();

    seg7_scan_driver #(.SCAN_BITS(SB)) dut (
        .CLK   (CLK),
        .RESET (RESET),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int errors = 0;
    logic compare_en = 1'b0;

    logic [6:0] glyph_tab [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    // Model: n counts cycles since reset release; slot position and digit follow from it.
    int          n;
    int          m_p;
    int          m_d;
    int          m_nib;
    logic        m_blank;
    logic [3:0]  m_onehot;
    logic [15:0] m_val;
    logic [3:0]  m_dp;
    logic [2:0]  m_br;
    logic [7:0]  e_hex;
    logic [3:0]  e_seg;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at n=%0d: got %h expected %h", nm, n, act, exp);
        end
    endtask

    always @(posedge CLK or posedge RESET) begin
        if (RESET) begin
            n = 0;
            m_val = 16'h0;
            m_dp = 4'h0;
            m_br = 3'd0;
            e_hex = 8'hFF;
            e_seg = 4'hF;
        end else begin
            m_p = n % SLOT;
            m_d = (n / SLOT) % 4;
            m_nib = int'((m_val >> (4 * m_d)) & 16'hF);
            m_blank = 1'b0;
`ifdef SEG7_LZB_EN
            m_blank = (m_d != 0) && ((m_val >> (4 * m_d)) == 16'h0);
`endif
            e_hex = {~m_dp[m_d], m_blank ? 7'h7F : glyph_tab[m_nib]};
            m_onehot = 4'b0001 << m_d;
            e_seg = (m_p < (int'(m_br) + 1) * PH) ? ~m_onehot : 4'hF;
            if (n % FRAME == FRAME - 1) begin
                m_val = bus.VALUE_IN;
                m_dp = bus.DP_IN;
                m_br = bus.BRIGHT;
            end
            n++;
        end
    end

    always @(negedge CLK) begin
        if (compare_en && !RESET) begin
            check("hex", 32'(bus.HEX_OUT), 32'(e_hex));
            check("seg", 32'(bus.SEG_SELECT), 32'(e_seg));
            check("tick", 32'(bus.FRAME_TICK), 32'((n % FRAME) == FRAME - 1));
            check("one_anode", 32'($countones(~bus.SEG_SELECT) <= 1), 32'd1);
        end
    end

    task automatic wait_n(input int target);
        int guard;
        guard = 0;
        while (n < target && guard < 5000) begin
            @(negedge CLK);
            guard++;
        end
        check("wait_bound", 32'(n >= target), 32'd1);
    endtask

    task automatic lit(input string nm, input int at, input logic [7:0] hex, input logic [3:0] seg);
        wait_n(at);
        check({nm, "_hex"}, 32'(bus.HEX_OUT), 32'(hex));
        check({nm, "_seg"}, 32'(bus.SEG_SELECT), 32'(seg));
    endtask

    logic [7:0] hex_1a2f [4] = '{8'h8E, 8'hA4, 8'h88, 8'hF9};

    initial begin
        bus.VALUE_IN = 16'h0;
        bus.DP_IN = 4'h0;
        bus.BRIGHT = 3'd0;
        #12;
        check("rst_hex", 32'(bus.HEX_OUT), 32'hFF);
        check("rst_seg", 32'(bus.SEG_SELECT), 32'hF);
        check("rst_tick", 32'(bus.FRAME_TICK), 32'h0);
        @(negedge CLK);
        #1 RESET = 1'b0;
        compare_en = 1'b1;
        bus.VALUE_IN = 16'h1A2F;
        bus.BRIGHT = 3'd7;

        lit("first_frame_0", 1, 8'hC0, 4'hE);
        lit("first_frame_dim", 3, 8'hC0, 4'hF);
        wait_n(63);
        check("tick_63", 32'(bus.FRAME_TICK), 32'h1);
        for (int k = 0; k < 4; k++) begin
            lit("v1a2f_start", 65 + 16 * k + 3, hex_1a2f[k], ~(4'b0001 << k));
            lit("v1a2f_end", 65 + 16 * k + 15, hex_1a2f[k], ~(4'b0001 << k));
        end

        wait_n(130);
        bus.VALUE_IN = 16'h1234;
        bus.DP_IN = 4'b0100;
        wait_n(213);
        bus.VALUE_IN = 16'h5678;
        lit("tear_dig2", 228, 8'h24, 4'hB);
        lit("tear_dig3", 244, 8'hF9, 4'h7);
        lit("new_dig0", 260, 8'h80, 4'hE);

        wait_n(262);
        bus.BRIGHT = 3'd2;
        lit("bright_on", 326, 8'h80, 4'hE);
        lit("bright_off", 327, 8'h80, 4'hF);

        wait_n(330);
        bus.VALUE_IN = 16'h0040;
        lit("lz_dig1", 401, 8'h99, 4'hD);
`ifdef SEG7_LZB_EN
        lit("lz_dig2", 417, 8'h7F, 4'hB);
        lit("lz_dig3", 433, 8'hFF, 4'h7);
`else
        lit("lz_dig2", 417, 8'h40, 4'hB);
        lit("lz_dig3", 433, 8'hC0, 4'h7);
`endif

        wait_n(487);
        #2 RESET = 1'b1;
        #1;
        check("mid_rst_hex", 32'(bus.HEX_OUT), 32'hFF);
        check("mid_rst_seg", 32'(bus.SEG_SELECT), 32'hF);
        check("mid_rst_tick", 32'(bus.FRAME_TICK), 32'h0);
        @(negedge CLK);
        #1 RESET = 1'b0;
        lit("post_rst", 1, 8'hC0, 4'hE);

        for (int i = 0; i < 150; i++) begin
            repeat ($urandom_range(1, 24)) @(negedge CLK);
            if ($urandom_range(0, 2) == 0)
                bus.VALUE_IN = 16'($urandom_range(0, 255));
            else
                bus.VALUE_IN = 16'($urandom);
            bus.DP_IN = 4'($urandom);
            bus.BRIGHT = 3'($urandom);
        end
        repeat (2 * FRAME) @(negedge CLK);

        compare_en = 1'b0;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
